// File: rtl/writeback_arb.sv
// Round-robin arbiter of NUM_SRC completion channels onto one register-file write port; aligns/extends load data, 1-cycle latency.
// Backpressure: ready is one-hot on the granted channel, losers hold valid. WRITEBACK_ARB_PERF_EN adds conflict_cnt_o.
module writeback_arb #(
  parameter  int XLEN      = 64,
  parameter  int NUM_SRC   = 3,
  parameter  int RF_ADDR_W = 5,
  localparam int OFF_W     = $clog2(XLEN/8)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  input  logic [NUM_SRC*RF_ADDR_W-1:0] src_rd_i,
  input  logic [NUM_SRC*XLEN-1:0]      src_data_i,
  input  logic [NUM_SRC-1:0]           src_is_load_i,
  input  logic [NUM_SRC*2-1:0]         src_byte_en_i,
  input  logic [NUM_SRC-1:0]           src_zero_extnd_i,
  input  logic [NUM_SRC*OFF_W-1:0]     src_row_idx_i,
  output logic                         rf_wr_en_o,
  output logic [RF_ADDR_W-1:0]         rf_wr_addr_o,
  output logic [XLEN-1:0]              rf_wr_data_o,
`ifdef WRITEBACK_ARB_PERF_EN
  output logic                         load_misalign_o,
  output logic [31:0]                  conflict_cnt_o
`else
  output logic                         load_misalign_o
`endif
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [RF_ADDR_W-1:0] rd_arr   [NUM_SRC];
  logic [XLEN-1:0]      data_arr [NUM_SRC];
  logic [1:0]           size_arr [NUM_SRC];
  logic [OFF_W-1:0]     off_arr  [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign rd_arr[i]   = src_rd_i[i*RF_ADDR_W +: RF_ADDR_W];
    assign data_arr[i] = src_data_i[i*XLEN +: XLEN];
    assign size_arr[i] = src_byte_en_i[i*2 +: 2];
    assign off_arr[i]  = src_row_idx_i[i*OFF_W +: OFF_W];
  end

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;
  logic [PTR_W:0]   cand;

  // Scan from the pointer upward with wrap; cand carries one spare bit for the fold.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_SRC)) cand = cand - (PTR_W+1)'(NUM_SRC);
      if (!grant_vld && src_valid_i[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    src_ready_o = '0;
    if (grant_vld) src_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_nxt = rr_ptr;
    if (grant_vld) ptr_nxt = (grant_idx == PTR_W'(NUM_SRC-1)) ? '0 : grant_idx + PTR_W'(1);
  end

  logic [RF_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]      sel_data;
  logic [1:0]           sel_size;
  logic [OFF_W-1:0]     sel_off;
  logic                 sel_is_load;
  logic                 sel_zx;

  assign sel_rd      = rd_arr[grant_idx];
  assign sel_data    = data_arr[grant_idx];
  assign sel_size    = size_arr[grant_idx];
  assign sel_off     = off_arr[grant_idx];
  assign sel_is_load = src_is_load_i[grant_idx];
  assign sel_zx      = src_zero_extnd_i[grant_idx];

  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  keep_mask;
  logic [XLEN-1:0]  fill;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  wr_data;
  logic [OFF_W-1:0] align_mask;
  logic             sign_bit;
  logic             misalign;
  logic             wr_now;

  assign shifted = sel_data >> {sel_off, 3'b000};

  // Mask-and-fill keeps one datapath for every size without zero-width replications at XLEN=32.
  always_comb begin
    keep_mask  = '1;
    sign_bit   = 1'b0;
    align_mask = '1;
    case (sel_size)
      2'b00: begin
        keep_mask  = XLEN'(8'hFF);
        sign_bit   = shifted[7];
        align_mask = '0;
      end
      2'b01: begin
        keep_mask  = XLEN'(16'hFFFF);
        sign_bit   = shifted[15];
        align_mask = OFF_W'(1);
      end
      2'b10: begin
        keep_mask  = XLEN'(32'hFFFF_FFFF);
        sign_bit   = shifted[31];
        align_mask = OFF_W'(3);
      end
      default: begin
        keep_mask  = '1;
        sign_bit   = 1'b0;
        align_mask = '1;
      end
    endcase
  end

  assign fill      = (sel_zx || sel_size == 2'b11) ? '0 : {XLEN{sign_bit}};
  assign load_data = (shifted & keep_mask) | (fill & ~keep_mask);
  assign wr_data   = sel_is_load ? load_data : sel_data;
  assign misalign  = sel_is_load &&
                     ((|(sel_off & align_mask)) || (sel_size == 2'b11 && XLEN == 32));
  assign wr_now    = grant_vld && (sel_rd != '0) && !misalign;

  // Address/data only move on a real write so consumers see the last written pair otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr          <= '0;
      rf_wr_en_o      <= 1'b0;
      rf_wr_addr_o    <= '0;
      rf_wr_data_o    <= '0;
      load_misalign_o <= 1'b0;
    end else begin
      rr_ptr          <= ptr_nxt;
      rf_wr_en_o      <= wr_now;
      load_misalign_o <= grant_vld && misalign;
      if (wr_now) begin
        rf_wr_addr_o <= sel_rd;
        rf_wr_data_o <= wr_data;
      end
    end
  end

`ifdef WRITEBACK_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conflict_cnt_o <= '0;
    end else if ((|(src_valid_i & ~src_ready_o)) && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule
